buf_arbiter: RTL and testbench

BUF_ARBITER -- requirements
Module: buf_arbiter

---
 rtl/buf_arbiter_if.sv | 47 ++++
 rtl/buf_arbiter.sv | 168 ++++++++++++++++
 tb/tb_buf_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buf_arbiter_if.sv
// Requester and buffer bus bundle for buf_arbiter.
// master: the arbiter's view (drives the buffer bus and requester replies).
// slave:  the environment's view (requesters and the buffer).
interface buf_arbiter_if;
  // Requester 0 (WB side)
  logic        R0_REQ;
  logic        R0_WE;
  logic [7:0]  R0_ADDR;
  logic [31:0] R0_DATA_I;
  logic [31:0] R0_DATA_O;
  logic        R0_ACK;
  logic        R0_ERR;
  // Requester 1 (SPI side)
  logic        R1_REQ;
  logic        R1_WE;
  logic [7:0]  R1_ADDR;
  logic [31:0] R1_DATA_I;
  logic [31:0] R1_DATA_O;
  logic        R1_ACK;
  logic        R1_ERR;
  // Shared buffer port
  logic        BUF_STB_O;
  logic        BUF_WRn;
  logic [7:0]  BUF_ADDR_O;
  logic [31:0] BUF_DATA_O;
  logic [31:0] BUF_DATA_I;
  logic        BUF_ACK;
  logic        GNT_O;

  modport master (
    input  R0_REQ, R0_WE, R0_ADDR, R0_DATA_I,
    input  R1_REQ, R1_WE, R1_ADDR, R1_DATA_I,
    input  BUF_DATA_I, BUF_ACK,
    output R0_DATA_O, R0_ACK, R0_ERR,
    output R1_DATA_O, R1_ACK, R1_ERR,
    output BUF_STB_O, BUF_WRn, BUF_ADDR_O, BUF_DATA_O, GNT_O
  );

  modport slave (
    output R0_REQ, R0_WE, R0_ADDR, R0_DATA_I,
    output R1_REQ, R1_WE, R1_ADDR, R1_DATA_I,
    output BUF_DATA_I, BUF_ACK,
    input  R0_DATA_O, R0_ACK, R0_ERR,
    input  R1_DATA_O, R1_ACK, R1_ERR,
    input  BUF_STB_O, BUF_WRn, BUF_ADDR_O, BUF_DATA_O, GNT_O
  );
endinterface

// File: rtl/buf_arbiter.sv
// Two-requester round-robin arbiter for a single shared buffer port.
// A granted access is latched onto the buffer bus, held until BUF_ACK,
// answered with a one-clock ACK to the owner, then followed by a one-clock
// RELEASE gap before the next arbitration.
// Optional feature: define BUF_ARB_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES clocks without BUF_ACK, answering the owner with ERR.
module buf_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          WB_CLK_I,
  input  logic          WB_RST_I,
  buf_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        stb_reg, stb_next;
  logic        wrn_reg, wrn_next;
  logic [7:0]  addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        gnt_reg, gnt_next;
  logic        ack0_reg, ack0_next;
  logic        ack1_reg, ack1_next;
  logic [31:0] rdata0_reg, rdata0_next;
  logic [31:0] rdata1_reg, rdata1_next;
  logic        win_sel;

`ifdef BUF_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_reg, cnt_next;
  logic        err0_reg, err0_next;
  logic        err1_reg, err1_next;
`endif

  // Reject out-of-range timeout limits at elaboration.
  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("buf_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end
  endgenerate

  // Winner: on a tie the requester not granted last, otherwise whoever asks.
  assign win_sel = (bus.R0_REQ && bus.R1_REQ) ? ~gnt_reg : bus.R1_REQ;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next  = state_reg;
    stb_next    = stb_reg;
    wrn_next    = wrn_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    gnt_next    = gnt_reg;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    rdata0_next = rdata0_reg;
    rdata1_next = rdata1_reg;
`ifdef BUF_ARB_TIMEOUT_EN
    cnt_next    = cnt_reg;
    err0_next   = 1'b0;
    err1_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.R0_REQ || bus.R1_REQ) begin
          gnt_next   = win_sel;
          wrn_next   = win_sel ? bus.R1_WE     : bus.R0_WE;
          addr_next  = win_sel ? bus.R1_ADDR   : bus.R0_ADDR;
          wdata_next = win_sel ? bus.R1_DATA_I : bus.R0_DATA_I;
          stb_next   = 1'b1;
          state_next = BUSY;
`ifdef BUF_ARB_TIMEOUT_EN
          cnt_next   = 8'd0;
`endif
        end
      end
      BUSY: begin
        // BUF_ACK is tested first so it wins over a timeout in the same cycle.
        if (bus.BUF_ACK) begin
          stb_next   = 1'b0;
          state_next = RELEASE;
          if (gnt_reg) ack1_next = 1'b1;
          else         ack0_next = 1'b1;
          if (!wrn_reg) begin
            if (gnt_reg) rdata1_next = bus.BUF_DATA_I;
            else         rdata0_next = bus.BUF_DATA_I;
          end
        end
`ifdef BUF_ARB_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          stb_next   = 1'b0;
          state_next = RELEASE;
          if (gnt_reg) err1_next = 1'b1;
          else         err0_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        stb_next   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge WB_CLK_I) begin
    if (WB_RST_I) begin
      state_reg  <= IDLE;
      stb_reg    <= 1'b0;
      wrn_reg    <= 1'b0;
      addr_reg   <= 8'd0;
      wdata_reg  <= 32'd0;
      gnt_reg    <= 1'b1;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      rdata0_reg <= 32'd0;
      rdata1_reg <= 32'd0;
`ifdef BUF_ARB_TIMEOUT_EN
      cnt_reg    <= 8'd0;
      err0_reg   <= 1'b0;
      err1_reg   <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      stb_reg    <= stb_next;
      wrn_reg    <= wrn_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      gnt_reg    <= gnt_next;
      ack0_reg   <= ack0_next;
      ack1_reg   <= ack1_next;
      rdata0_reg <= rdata0_next;
      rdata1_reg <= rdata1_next;
`ifdef BUF_ARB_TIMEOUT_EN
      cnt_reg    <= cnt_next;
      err0_reg   <= err0_next;
      err1_reg   <= err1_next;
`endif
    end
  end

  assign bus.BUF_STB_O  = stb_reg;
  assign bus.BUF_WRn    = wrn_reg;
  assign bus.BUF_ADDR_O = addr_reg;
  assign bus.BUF_DATA_O = wdata_reg;
  assign bus.GNT_O      = gnt_reg;
  assign bus.R0_ACK     = ack0_reg;
  assign bus.R1_ACK     = ack1_reg;
  assign bus.R0_DATA_O  = rdata0_reg;
  assign bus.R1_DATA_O  = rdata1_reg;
`ifdef BUF_ARB_TIMEOUT_EN
  assign bus.R0_ERR     = err0_reg;
  assign bus.R1_ERR     = err1_reg;
`else
  assign bus.R0_ERR     = 1'b0;
  assign bus.R1_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_buf_arbiter.sv
// Self-checking bench for buf_arbiter: directed scenarios plus randomized
// request patterns checked against a transaction-level model (last owner,
// expected read-data registers). Honours BUF_ARB_TIMEOUT_EN if defined.
module tb_buf_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buf_arbiter_if bus();

  buf_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .WB_CLK_I(clk),
    .WB_RST_I(rst),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: who owned the buffer last, and each requester's read data.
  logic        last_gnt;
  logic [31:0] exp_rd [2];

  typedef struct {
    bit          got;
    logic        gnt;
    logic        wrn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          stable;
    int          scyc;
    logic        ack0, ack1, err0, err1, stb_after;
    logic [31:0] rd0, rd1;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int r, input logic we, input logic [7:0] a, input logic [31:0] d);
    if (r == 0) begin
      bus.R0_REQ = 1'b1; bus.R0_WE = we; bus.R0_ADDR = a; bus.R0_DATA_I = d;
    end else begin
      bus.R1_REQ = 1'b1; bus.R1_WE = we; bus.R1_ADDR = a; bus.R1_DATA_I = d;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.R0_REQ = 0; bus.R0_WE = 0; bus.R0_ADDR = 0; bus.R0_DATA_I = 0;
    bus.R1_REQ = 0; bus.R1_WE = 0; bus.R1_ADDR = 0; bus.R1_DATA_I = 0;
    bus.BUF_ACK = 0; bus.BUF_DATA_I = 0;
    step(); step();
    last_gnt  = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  // Acts as the buffer: waits for a strobe, answers BUF_ACK `delay` cycles later,
  // and records what the arbiter showed. The owner drops REQ once its ACK appears.
  task automatic serve_one(input int delay, input logic [31:0] rdata, input bit drop_early, output obs_t o);
    o.got = 0; o.stable = 0; o.scyc = 0;
    for (int i = 0; i < 20 && bus.BUF_STB_O !== 1'b1; i++) step();
    if (bus.BUF_STB_O !== 1'b1) return;
    o.got = 1; o.stable = 1; o.scyc = cyc;
    o.gnt = bus.GNT_O; o.wrn = bus.BUF_WRn; o.addr = bus.BUF_ADDR_O; o.wdata = bus.BUF_DATA_O;
    if (drop_early) begin
      if (o.gnt) bus.R1_REQ = 1'b0;
      else       bus.R0_REQ = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      step();
      if (bus.BUF_STB_O !== 1'b1 || bus.BUF_WRn !== o.wrn || bus.BUF_ADDR_O !== o.addr ||
          bus.BUF_DATA_O !== o.wdata || bus.GNT_O !== o.gnt) o.stable = 0;
    end
    bus.BUF_ACK = 1'b1; bus.BUF_DATA_I = rdata;
    step();
    bus.BUF_ACK = 1'b0; bus.BUF_DATA_I = $urandom;
    o.ack0 = bus.R0_ACK; o.ack1 = bus.R1_ACK; o.err0 = bus.R0_ERR; o.err1 = bus.R1_ERR;
    o.stb_after = bus.BUF_STB_O; o.rd0 = bus.R0_DATA_O; o.rd1 = bus.R1_DATA_O;
    if (o.ack0 === 1'b1) bus.R0_REQ = 1'b0;
    if (o.ack1 === 1'b1) bus.R1_REQ = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.BUF_STB_O !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", bus.BUF_STB_O); end
    checks++; if (bus.BUF_WRn !== 1'b0) begin failures++; $display("FAIL reset_wrn got=%b exp=0", bus.BUF_WRn); end
    checks++; if (bus.BUF_ADDR_O !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", bus.BUF_ADDR_O); end
    checks++; if (bus.BUF_DATA_O !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.BUF_DATA_O); end
    checks++; if (bus.GNT_O !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b exp=1", bus.GNT_O); end
    checks++; if ({bus.R0_ACK, bus.R1_ACK, bus.R0_ERR, bus.R1_ERR} !== 4'b0) begin
      failures++; $display("FAIL reset_ack_err got=%b exp=0000", {bus.R0_ACK, bus.R1_ACK, bus.R0_ERR, bus.R1_ERR}); end
    checks++; if (bus.R0_DATA_O !== 32'h0 || bus.R1_DATA_O !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.R0_DATA_O, bus.R1_DATA_O); end
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    obs_t o;
    raise(0, 1'b0, 8'h05, 32'h0);
    serve_one(2, 32'hDEADBEEF, 1'b0, o);
    checks++; if (!o.got) begin failures++; $display("FAIL rd_strobe got=none exp=strobe"); end
    if (o.got) begin
      exp_rd[0] = 32'hDEADBEEF; last_gnt = 1'b0;
      checks++; if (o.gnt !== 1'b0 || o.wrn !== 1'b0 || o.addr !== 8'h05) begin
        failures++; $display("FAIL rd_bus got=gnt%b wrn%b addr%h exp=gnt0 wrn0 addr05", o.gnt, o.wrn, o.addr); end
      checks++; if (!o.stable) begin failures++; $display("FAIL rd_stable got=changed exp=held"); end
      checks++; if (o.ack0 !== 1'b1 || o.ack1 !== 1'b0 || o.stb_after !== 1'b0) begin
        failures++; $display("FAIL rd_ack got=ack0%b ack1%b stb%b exp=ack0 1 ack1 0 stb0", o.ack0, o.ack1, o.stb_after); end
      checks++; if (o.rd0 !== exp_rd[0] || o.rd1 !== exp_rd[1]) begin
        failures++; $display("FAIL rd_data got=%h/%h exp=%h/%h", o.rd0, o.rd1, exp_rd[0], exp_rd[1]); end
      step();
      checks++; if (bus.R0_ACK !== 1'b0) begin failures++; $display("FAIL rd_ack_width got=%b exp=0", bus.R0_ACK); end
    end
  endtask

  task automatic test_write_spacing();
    obs_t o1, o2;
    logic [31:0] rv;
    raise(1, 1'b1, 8'hFF, 32'h12345678);
    serve_one(0, 32'hCAFEF00D, 1'b0, o1);
    checks++; if (!o1.got) begin failures++; $display("FAIL wr_strobe got=none exp=strobe"); end
    if (o1.got) begin
      last_gnt = 1'b1;
      checks++; if (o1.gnt !== 1'b1 || o1.wrn !== 1'b1 || o1.addr !== 8'hFF || o1.wdata !== 32'h12345678) begin
        failures++; $display("FAIL wr_bus got=gnt%b wrn%b %h %h exp=gnt1 wrn1 ff 12345678", o1.gnt, o1.wrn, o1.addr, o1.wdata); end
      checks++; if (o1.ack1 !== 1'b1 || o1.ack0 !== 1'b0) begin
        failures++; $display("FAIL wr_ack got=ack1%b ack0%b exp=1 0", o1.ack1, o1.ack0); end
      checks++; if (o1.rd1 !== exp_rd[1] || o1.rd0 !== exp_rd[0]) begin
        failures++; $display("FAIL wr_data_kept got=%h/%h exp=%h/%h", o1.rd0, o1.rd1, exp_rd[0], exp_rd[1]); end
      // Re-request at once: strobe cycles span BUSY, RELEASE, IDLE, BUSY -> four clocks
      // counting the first strobe cycle, i.e. the next strobe starts 3 clocks later.
      rv = $urandom;
      raise(1, 1'b0, 8'($urandom), 32'h0);
      serve_one(1, rv, 1'b0, o2);
      checks++; if (!o2.got || (o2.scyc - o1.scyc) !== 3) begin
        failures++; $display("FAIL wr_spacing got=%0d exp=3", o2.scyc - o1.scyc); end
      if (o2.got) exp_rd[1] = rv;
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [31:0] rv;
    logic        exp_g;
    logic        we;
    apply_reset();
    rst = 1'b0;
    raise(0, 1'($urandom), 8'($urandom), $urandom);
    raise(1, 1'($urandom), 8'($urandom), $urandom);
    for (int k = 0; k < 4; k++) begin
      exp_g = 1'(k % 2);
      we = (exp_g ? bus.R1_WE : bus.R0_WE);
      rv = $urandom;
      serve_one($urandom_range(0, 2), rv, 1'b0, o);
      if (o.got && !we) exp_rd[exp_g] = rv;
      checks++; if (!o.got || o.gnt !== exp_g) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, o.gnt, exp_g); end
      checks++; if (o.ack0 !== !exp_g || o.ack1 !== exp_g || o.rd0 !== exp_rd[0] || o.rd1 !== exp_rd[1]) begin
        failures++; $display("FAIL rr_ack%0d got=%b%b %h/%h exp=%b%b %h/%h", k, o.ack0, o.ack1, o.rd0, o.rd1,
                             !exp_g, exp_g, exp_rd[0], exp_rd[1]); end
      raise(int'(exp_g), 1'($urandom), 8'($urandom), $urandom);
    end
    bus.R0_REQ = 1'b0; bus.R1_REQ = 1'b0;
    last_gnt = 1'b1;
    step();
  endtask

  task automatic test_stray_ack();
    obs_t o;
    logic [31:0] rv;
    bit bad;
    bad = 0;
    bus.BUF_ACK = 1'b1; bus.BUF_DATA_I = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.R0_ACK !== 1'b0 || bus.R1_ACK !== 1'b0 || bus.BUF_STB_O !== 1'b0 || bus.R0_DATA_O !== exp_rd[0]) bad = 1;
    end
    bus.BUF_ACK = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL idle_ack_ignored got=reacted exp=ignored"); end
    rv = $urandom;
    raise(0, 1'b0, 8'($urandom), 32'h0);
    serve_one(1, rv, 1'b0, o);
    exp_rd[0] = rv; last_gnt = 1'b0;
    // BUF_ACK now lands in the RELEASE cycle and the following IDLE cycle.
    bus.BUF_ACK = 1'b1; bus.BUF_DATA_I = ~rv;
    step(); step();
    bus.BUF_ACK = 1'b0;
    checks++; if (bus.R0_ACK !== 1'b0 || bus.BUF_STB_O !== 1'b0 || bus.R0_DATA_O !== exp_rd[0]) begin
      failures++; $display("FAIL release_ack_ignored got=ack%b stb%b %h exp=ack0 stb0 %h", bus.R0_ACK, bus.BUF_STB_O,
                           bus.R0_DATA_O, exp_rd[0]); end
  endtask

  task automatic test_random();
    obs_t o;
    bit          pend [2];
    logic        rq_we [2];
    logic [7:0]  rq_addr [2];
    logic [31:0] rq_data [2];
    logic [31:0] rv;
    logic        exp_w;
    int          pat;
    for (int it = 0; it < 30; it++) begin
      pat = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        pend[r] = pat[r];
        rq_we[r] = 1'($urandom); rq_addr[r] = 8'($urandom); rq_data[r] = $urandom;
        if (pend[r]) raise(r, rq_we[r], rq_addr[r], rq_data[r]);
      end
      while (pend[0] || pend[1]) begin
        // Both waiting: the one that did not go last. Otherwise the only one waiting.
        if (pend[0] && pend[1]) exp_w = ~last_gnt;
        else                    exp_w = pend[1];
        rv = $urandom;
        serve_one($urandom_range(0, 3), rv, ($urandom_range(0, 7) == 0), o);
        checks++; if (!o.got) begin failures++; $display("FAIL rand_strobe it=%0d got=none exp=strobe", it); break; end
        if (!rq_we[exp_w]) exp_rd[exp_w] = rv;
        last_gnt = exp_w;
        pend[exp_w] = 0;
        checks++; if (o.gnt !== exp_w) begin failures++; $display("FAIL rand_gnt it=%0d got=%b exp=%b", it, o.gnt, exp_w); end
        checks++; if (o.wrn !== rq_we[exp_w] || o.addr !== rq_addr[exp_w] || o.wdata !== rq_data[exp_w] || !o.stable) begin
          failures++; $display("FAIL rand_bus it=%0d got=%b %h %h st%0d exp=%b %h %h st1", it, o.wrn, o.addr, o.wdata,
                               o.stable, rq_we[exp_w], rq_addr[exp_w], rq_data[exp_w]); end
        checks++; if (o.ack0 !== !exp_w || o.ack1 !== exp_w || o.err0 !== 1'b0 || o.err1 !== 1'b0 || o.stb_after !== 1'b0) begin
          failures++; $display("FAIL rand_ack it=%0d got=%b%b err%b%b stb%b exp=%b%b err00 stb0", it, o.ack0, o.ack1,
                               o.err0, o.err1, o.stb_after, !exp_w, exp_w); end
        checks++; if (o.rd0 !== exp_rd[0] || o.rd1 !== exp_rd[1]) begin
          failures++; $display("FAIL rand_rdata it=%0d got=%h/%h exp=%h/%h", it, o.rd0, o.rd1, exp_rd[0], exp_rd[1]); end
      end
      bus.R0_REQ = 1'b0; bus.R1_REQ = 1'b0;
      step();
      checks++; if (bus.R0_ACK !== 1'b0 || bus.R1_ACK !== 1'b0) begin
        failures++; $display("FAIL rand_ack_width it=%0d got=%b%b exp=00", it, bus.R0_ACK, bus.R1_ACK); end
    end
  endtask

  task automatic test_reset_busy();
    obs_t o;
    bit bad;
    int c0;
    logic [31:0] rv;
    raise(0, 1'b1, 8'hA5, 32'h5A5A5A5A);
    for (int i = 0; i < 10 && bus.BUF_STB_O !== 1'b1; i++) step();
    step();
    rst = 1'b1;
    step();
    last_gnt = 1'b1; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    checks++; if (bus.BUF_STB_O !== 1'b0 || bus.BUF_WRn !== 1'b0 || bus.BUF_ADDR_O !== 8'h0 || bus.BUF_DATA_O !== 32'h0 ||
                  bus.GNT_O !== 1'b1 || bus.R0_DATA_O !== 32'h0 || bus.R1_DATA_O !== 32'h0) begin
      failures++; $display("FAIL rstbusy_vals got=stb%b wrn%b %h %h gnt%b %h %h exp=0 0 00 0 1 0 0", bus.BUF_STB_O,
                           bus.BUF_WRn, bus.BUF_ADDR_O, bus.BUF_DATA_O, bus.GNT_O, bus.R0_DATA_O, bus.R1_DATA_O); end
    rst = 1'b0; bus.R0_REQ = 1'b0;
    bus.BUF_ACK = 1'b1; bus.BUF_DATA_I = $urandom;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.R0_ACK !== 1'b0 || bus.R1_ACK !== 1'b0 || bus.R0_ERR !== 1'b0 || bus.R1_ERR !== 1'b0 || bus.BUF_STB_O !== 1'b0) bad = 1;
    end
    bus.BUF_ACK = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL rstbusy_no_pulse got=pulse exp=none"); end
    // Back in IDLE: a fresh request strobes on the very next clock.
    c0 = cyc; rv = $urandom;
    raise(1, 1'b0, 8'h33, 32'h0);
    serve_one(1, rv, 1'b0, o);
    checks++; if (!o.got || o.scyc !== c0 + 1 || o.gnt !== 1'b1 || o.ack1 !== 1'b1 || o.rd1 !== rv) begin
      failures++; $display("FAIL rstbusy_idle got=lat%0d gnt%b ack%b %h exp=lat1 gnt1 ack1 %h", o.scyc - c0, o.gnt,
                           o.ack1, o.rd1, rv); end
    if (o.got) begin exp_rd[1] = rv; last_gnt = 1'b1; end
    step();
  endtask

  task automatic test_timeout();
    obs_t o;
    int n;
    logic [31:0] rv;
`ifdef BUF_ARB_TIMEOUT_EN
    raise(1, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 10 && bus.BUF_STB_O !== 1'b1; i++) step();
    n = (bus.BUF_STB_O === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.BUF_STB_O === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL to_busy_len got=%0d exp=16", n); end
    checks++; if (bus.R1_ERR !== 1'b1 || bus.R1_ACK !== 1'b0 || bus.R0_ERR !== 1'b0 || bus.R1_DATA_O !== exp_rd[1]) begin
      failures++; $display("FAIL to_err got=err%b ack%b err0%b %h exp=err1 ack0 err0 0 %h", bus.R1_ERR, bus.R1_ACK,
                           bus.R0_ERR, bus.R1_DATA_O, exp_rd[1]); end
    bus.R1_REQ = 1'b0; last_gnt = 1'b1;
    step();
    checks++; if (bus.R1_ERR !== 1'b0) begin failures++; $display("FAIL to_err_width got=%b exp=0", bus.R1_ERR); end
    // BUF_ACK in the 16th BUSY cycle beats the timeout.
    rv = $urandom;
    raise(0, 1'b0, 8'h20, 32'h0);
    serve_one(15, rv, 1'b0, o);
    checks++; if (!o.got || o.ack0 !== 1'b1 || o.err0 !== 1'b0 || o.rd0 !== rv || o.gnt !== 1'b0) begin
      failures++; $display("FAIL to_ack_wins got=ack%b err%b %h gnt%b exp=ack1 err0 %h gnt0", o.ack0, o.err0, o.rd0, o.gnt, rv); end
    if (o.got) begin exp_rd[0] = rv; last_gnt = 1'b0; end
`else
    raise(1, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 10 && bus.BUF_STB_O !== 1'b1; i++) step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.BUF_STB_O !== 1'b1 || bus.R0_ERR !== 1'b0 || bus.R1_ERR !== 1'b0) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL nto_wait got=%0d_bad_cycles exp=0", n); end
    rv = $urandom;
    serve_one(0, rv, 1'b0, o);
    checks++; if (!o.got || o.ack1 !== 1'b1 || o.rd1 !== rv) begin
      failures++; $display("FAIL nto_finish got=ack%b %h exp=ack1 %h", o.ack1, o.rd1, rv); end
    if (o.got) begin exp_rd[1] = rv; last_gnt = 1'b1; end
`endif
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_read_basic();
    test_write_spacing();
    test_round_robin();
    test_stray_ack();
    test_random();
    test_reset_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
